uart_io_buffer: RTL and testbench

- Buffered I/O unit between the uart_rx/uart_tx pair and the core's IN/OUT instructions.
- Replaces the unbounded receive ring and the direct-drive transmit path inside the core.
- Adds a parametrised RX byte FIFO with full/overflow detection, a TX byte FIFO, and byte or 32-bit word transfers per request.
- TX drains autonomously to uart_tx.

---
 rtl/uart_io_pkg.sv | 27 ++
 rtl/sync_byte_ram.sv | 34 +++
 rtl/uart_io_buffer.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_uart_io_buffer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_io_pkg.sv
// Shared definitions for the buffered UART I/O unit.
//   - State encodings for the IN, OUT and TX drain state machines.
//   - BYTES_PER_WORD: bytes moved by a word-sized IN/OUT transfer.
//   - LINK_SYNC_BYTE: link synchronisation byte, also used by the loader.
package uart_io_pkg;

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_FETCH,
        IN_ACK
    } in_state_e;

    typedef enum logic {
        OUT_IDLE,
        OUT_ACK
    } out_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT
    } tx_state_e;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] LINK_SYNC_BYTE = 8'hAA;

endpackage

// File: rtl/sync_byte_ram.sv
// Byte-wide storage with one write port and one synchronous read port,
// written so synthesis can map it onto block RAM.
// Ports:
//   clk      - clock
//   wr_en    - write strobe, stores wr_data at wr_addr
//   wr_addr  - write address
//   wr_data  - write byte
//   rd_en    - read strobe, rd_data updates on the next clock edge
//   rd_addr  - read address
//   rd_data  - registered read byte, holds while rd_en is low
module sync_byte_ram #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_io_buffer.sv
// Buffered I/O between uart_rx/uart_tx and the core's IN/OUT instructions.
// RX bytes land in a RAM-backed FIFO; IN requests pull one byte or a
// little-endian 32-bit word. OUT requests push one or four bytes into a
// register TX FIFO which drains to uart_tx on its own.
// Optional build macro IO_STATS_EN enables the saturating RX statistics
// counters; without it stat_rx_total/stat_rx_drop are tied to zero.
// Ports:
//   clk, rstn                  - clock, asynchronous active-low reset
//   rx_data/rx_ready/ferr      - byte, strobe and framing error from uart_rx
//   tx_data/tx_start/tx_busy   - byte, start strobe and busy of uart_tx
//   in_req/in_word             - IN request level, word (1) or byte (0)
//   in_ack/in_data             - IN completion pulse and received data
//   out_req/out_word/out_data  - OUT request level, size and data
//   out_ack                    - OUT completion pulse
//   rx_count                   - bytes currently held in the RX FIFO
//   rx_overflow/clr_overflow   - sticky RX overflow flag and its clear
//   stat_rx_total/stat_rx_drop - accepted / dropped RX byte counters
module uart_io_buffer
    import uart_io_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = 15,
    parameter int TX_DEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [7:0]             rx_data,
    input  logic                   rx_ready,
    input  logic                   ferr,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    input  logic                   in_req,
    input  logic                   in_word,
    output logic                   in_ack,
    output logic [31:0]            in_data,
    input  logic                   out_req,
    input  logic                   out_word,
    input  logic [31:0]            out_data,
    output logic                   out_ack,
    output logic [RX_DEPTH_LOG2:0] rx_count,
    output logic                   rx_overflow,
    input  logic                   clr_overflow,
    output logic [31:0]            stat_rx_total,
    output logic [31:0]            stat_rx_drop
);

    localparam int RXW      = RX_DEPTH_LOG2 + 1;
    localparam int TXW      = TX_DEPTH_LOG2 + 1;
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;

    // RX FIFO control
    logic [RXW-1:0]           rx_count_q, rx_count_d;
    logic [RX_DEPTH_LOG2-1:0] rx_head_q, rx_head_d;
    logic [RX_DEPTH_LOG2-1:0] rx_tail_q, rx_tail_d;
    logic                     rx_overflow_q, rx_overflow_d;
    logic                     rx_full, rx_push, rx_pop;

    // RX storage read port
    logic                     rd_en;
    logic [RX_DEPTH_LOG2-1:0] rd_addr;
    logic [7:0]               rd_data;

    // IN state machine
    in_state_e   in_state_q, in_state_d;
    logic        in_word_q, in_word_d;
    logic [1:0]  in_idx_q, in_idx_d;
    logic [31:0] in_asm_q, in_asm_d;
    logic        in_ack_q, in_ack_d;
    logic [31:0] in_data_q, in_data_d;
    logic        in_last;

    // TX FIFO, OUT and drain state machines
    logic [7:0]               tx_mem_q [TX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] tx_head_q, tx_head_d;
    logic [TX_DEPTH_LOG2-1:0] tx_tail_q, tx_tail_d;
    logic [TXW-1:0]           tx_cnt_q, tx_cnt_d;
    logic                     tx_wr, tx_pop;
    logic [2:0]               tx_wr_n;
    out_state_e               out_state_q, out_state_d;
    logic                     out_ack_q, out_ack_d;
    tx_state_e                tx_state_q, tx_state_d;
    logic                     tx_start_q, tx_start_d;
    logic [7:0]               tx_data_q, tx_data_d;

    sync_byte_ram #(.ADDR_W(RX_DEPTH_LOG2)) u_rx_ram (
        .clk     (clk),
        .wr_en   (rx_push),
        .wr_addr (rx_tail_q),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Fullness uses the registered count only, so a byte arriving in the
    // same cycle as an IN pop from a full FIFO is still dropped.
    always_comb begin
        rx_full   = (int'(rx_count_q) == RX_DEPTH);
        rx_push   = rx_ready && !ferr && !rx_full;
        rx_tail_d = rx_push ? rx_tail_q + RX_DEPTH_LOG2'(1) : rx_tail_q;
        // A new overflow wins over a same-cycle clear.
        if (rx_ready && !ferr && rx_full) begin
            rx_overflow_d = 1'b1;
        end else if (clr_overflow) begin
            rx_overflow_d = 1'b0;
        end else begin
            rx_overflow_d = rx_overflow_q;
        end
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + RXW'(1);
            2'b01:   rx_count_d = rx_count_q - RXW'(1);
            default: rx_count_d = rx_count_q;
        endcase
    end

    // IN: one RAM read is in flight ahead of each capture, so the byte
    // read in cycle t is captured in cycle t+1 while the next is issued.
    always_comb begin
        in_state_d = in_state_q;
        in_word_d  = in_word_q;
        in_idx_d   = in_idx_q;
        in_asm_d   = in_asm_q;
        in_ack_d   = 1'b0;
        in_data_d  = in_data_q;
        rx_head_d  = rx_head_q;
        rx_pop     = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = rx_head_q;
        in_last    = (in_idx_q == (in_word_q ? 2'd3 : 2'd0));
        case (in_state_q)
            IN_IDLE: begin
                if (in_req && (int'(rx_count_q) >= (in_word ? BYTES_PER_WORD : 1))) begin
                    rd_en      = 1'b1;
                    in_word_d  = in_word;
                    in_idx_d   = 2'd0;
                    in_asm_d   = 32'd0;
                    in_state_d = IN_FETCH;
                end
            end
            IN_FETCH: begin
                rx_pop                      = 1'b1;
                rx_head_d                   = rx_head_q + RX_DEPTH_LOG2'(1);
                in_asm_d[{in_idx_q, 3'b000} +: 8] = rd_data;
                if (in_last) begin
                    in_ack_d   = 1'b1;
                    in_data_d  = in_asm_d;
                    in_state_d = IN_ACK;
                end else begin
                    in_idx_d = in_idx_q + 2'd1;
                    rd_en    = 1'b1;
                    rd_addr  = rx_head_d;
                end
            end
            IN_ACK:  in_state_d = IN_IDLE;
            default: in_state_d = IN_IDLE;
        endcase
    end

    // OUT writes and drain pops may land in the same cycle.
    always_comb begin
        out_state_d = out_state_q;
        out_ack_d   = 1'b0;
        tx_wr       = 1'b0;
        tx_state_d  = tx_state_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        tx_pop      = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (out_req && (int'(tx_cnt_q) + (out_word ? BYTES_PER_WORD : 1) <= TX_DEPTH)) begin
                    tx_wr       = 1'b1;
                    out_ack_d   = 1'b1;
                    out_state_d = OUT_ACK;
                end
            end
            OUT_ACK: out_state_d = OUT_IDLE;
            default: out_state_d = OUT_IDLE;
        endcase
        case (tx_state_q)
            TX_IDLE: begin
                if ((tx_cnt_q != '0) && !tx_busy) begin
                    tx_pop     = 1'b1;
                    tx_data_d  = tx_mem_q[tx_head_q];
                    tx_start_d = 1'b1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: tx_state_d = TX_WAIT;
            // Gives uart_tx one cycle to raise tx_busy after the strobe.
            TX_WAIT:  tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
        tx_wr_n   = !tx_wr ? 3'd0 : (out_word ? 3'(BYTES_PER_WORD) : 3'd1);
        tx_tail_d = tx_tail_q + TX_DEPTH_LOG2'(tx_wr_n);
        tx_head_d = tx_pop ? tx_head_q + TX_DEPTH_LOG2'(1) : tx_head_q;
        tx_cnt_d  = tx_cnt_q + TXW'(tx_wr_n) - TXW'(tx_pop);
    end

    // TX byte storage, least significant byte first in queue order.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (tx_wr && (i == 0 || out_word)) begin
                tx_mem_q[tx_tail_q + TX_DEPTH_LOG2'(i)] <= out_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_count_q    <= '0;
            rx_head_q     <= '0;
            rx_tail_q     <= '0;
            rx_overflow_q <= 1'b0;
            in_state_q    <= IN_IDLE;
            in_word_q     <= 1'b0;
            in_idx_q      <= 2'd0;
            in_asm_q      <= 32'd0;
            in_ack_q      <= 1'b0;
            in_data_q     <= 32'd0;
            tx_head_q     <= '0;
            tx_tail_q     <= '0;
            tx_cnt_q      <= '0;
            out_state_q   <= OUT_IDLE;
            out_ack_q     <= 1'b0;
            tx_state_q    <= TX_IDLE;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'd0;
        end else begin
            rx_count_q    <= rx_count_d;
            rx_head_q     <= rx_head_d;
            rx_tail_q     <= rx_tail_d;
            rx_overflow_q <= rx_overflow_d;
            in_state_q    <= in_state_d;
            in_word_q     <= in_word_d;
            in_idx_q      <= in_idx_d;
            in_asm_q      <= in_asm_d;
            in_ack_q      <= in_ack_d;
            in_data_q     <= in_data_d;
            tx_head_q     <= tx_head_d;
            tx_tail_q     <= tx_tail_d;
            tx_cnt_q      <= tx_cnt_d;
            out_state_q   <= out_state_d;
            out_ack_q     <= out_ack_d;
            tx_state_q    <= tx_state_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
        end
    end

    assign rx_count    = rx_count_q;
    assign rx_overflow = rx_overflow_q;
    assign in_ack      = in_ack_q;
    assign in_data     = in_data_q;
    assign out_ack     = out_ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;

`ifdef IO_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] stat_total_q, stat_total_d;
    logic [31:0] stat_drop_q, stat_drop_d;

    always_comb begin
        stat_total_d = rx_push ? sat_inc(stat_total_q) : stat_total_q;
        stat_drop_d  = (rx_ready && (ferr || rx_full)) ? sat_inc(stat_drop_q) : stat_drop_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_total_q <= 32'd0;
            stat_drop_q  <= 32'd0;
        end else begin
            stat_total_q <= stat_total_d;
            stat_drop_q  <= stat_drop_d;
        end
    end

    assign stat_rx_total = stat_total_q;
    assign stat_rx_drop  = stat_drop_q;
`else
    assign stat_rx_total = 32'd0;
    assign stat_rx_drop  = 32'd0;
`endif

endmodule

// File: tb/tb_uart_io_buffer.sv
// Randomised scoreboard bench for uart_io_buffer with a small RX FIFO.
module tb_uart_io_buffer;

    localparam int RXL = 2;
    localparam int TXL = 4;
    localparam int RXD = 1 << RXL;
    localparam int TXD = 1 << TXL;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_ready = 1'b0;
    logic          ferr = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          in_req = 1'b0;
    logic          in_word = 1'b0;
    logic          in_ack;
    logic [31:0]   in_data;
    logic          out_req = 1'b0;
    logic          out_word = 1'b0;
    logic [31:0]   out_data = 32'd0;
    logic          out_ack;
    logic [RXL:0]  rx_count;
    logic          rx_overflow;
    logic          clr_overflow = 1'b0;
    logic [31:0]   stat_rx_total;
    logic [31:0]   stat_rx_drop;

    uart_io_buffer #(.RX_DEPTH_LOG2(RXL), .TX_DEPTH_LOG2(TXL)) dut (
        .clk(clk), .rstn(rstn),
        .rx_data(rx_data), .rx_ready(rx_ready), .ferr(ferr),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .in_req(in_req), .in_word(in_word), .in_ack(in_ack), .in_data(in_data),
        .out_req(out_req), .out_word(out_word), .out_data(out_data), .out_ack(out_ack),
        .rx_count(rx_count), .rx_overflow(rx_overflow), .clr_overflow(clr_overflow),
        .stat_rx_total(stat_rx_total), .stat_rx_drop(stat_rx_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx stand-in: busy from the cycle after tx_start for busy_len cycles.
    int busy_len = 4;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Reference model and scoreboards.
    logic [7:0]  m_rx[$];
    bit          m_ovf = 0;
    int          m_total = 0, m_drop = 0;
    logic [31:0] exp_in_q[$];
    logic [7:0]  exp_tx_q[$];
    int          tx_pushed = 0, tx_started = 0;
    int          n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic [7:0] d, input bit fe);
        if (fe) m_drop++;
        else if (m_rx.size() < RXD) begin m_rx.push_back(d); m_total++; end
        else begin m_ovf = 1; m_drop++; end
    endtask

    function automatic logic [31:0] model_pop(input int n);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = m_rx.pop_front();
        return v;
    endfunction

    task automatic push_byte(input logic [7:0] d, input bit fe);
        tick();
        rx_data = d; rx_ready = 1'b1; ferr = fe;
        model_push(d, fe);
        tick();
        rx_ready = 1'b0; ferr = 1'b0;
    endtask

    task automatic pulse_clr();
        tick();
        clr_overflow = 1'b1;
        m_ovf = 0;
        tick();
        clr_overflow = 1'b0;
    endtask

    task automatic check_rx_state(input string tag);
        @(negedge clk);
        chk({tag, " rx_count"}, 32'(rx_count), m_rx.size());
        chk({tag, " rx_overflow"}, 32'(rx_overflow), 32'(m_ovf));
`ifdef IO_STATS_EN
        chk({tag, " stat_rx_total"}, stat_rx_total, m_total);
        chk({tag, " stat_rx_drop"}, stat_rx_drop, m_drop);
`else
        chk({tag, " stat_rx_total"}, stat_rx_total, 32'd0);
        chk({tag, " stat_rx_drop"}, stat_rx_drop, 32'd0);
`endif
    endtask

    task automatic do_in(input bit word);
        int n = word ? 4 : 1;
        int t0;
        bit got = 0;
        exp_in_q.push_back(model_pop(n));
        tick();
        in_word = word; in_req = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ack) begin got = 1; break; end
        end
        in_req = 1'b0;
        if (got) chk("in_ack latency", cyc - t0, n + 1);
        else begin chk("in_ack timeout", 32'(in_ack), 32'd1); exp_in_q.delete(); end
    endtask

    task automatic do_in_starved(input bit word);
        bit seen = 0;
        tick();
        in_word = word; in_req = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (in_ack) seen = 1;
        end
        in_req = 1'b0;
        chk("starved IN acked", 32'(seen), 32'd0);
    endtask

    task automatic do_out(input bit word, input logic [31:0] data);
        int n = word ? 4 : 1;
        int t0;
        bit exact, got = 0;
        tick();
        exact = (tx_pushed - tx_started + n <= TXD);
        out_word = word; out_data = data; out_req = 1'b1;
        for (int i = 0; i < n; i++) exp_tx_q.push_back(data[8*i +: 8]);
        tx_pushed += n;
        t0 = cyc;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (out_ack) begin got = 1; break; end
        end
        out_req = 1'b0;
        if (!got) chk("out_ack timeout", 32'(out_ack), 32'd1);
        else if (exact) chk("out_ack latency", cyc - t0, 1);
    endtask

    task automatic wait_tx_drain();
        for (int i = 0; i < 2000 && exp_tx_q.size() != 0; i++) @(negedge clk);
        repeat (12) @(negedge clk);
        chk("tx queue drained", exp_tx_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, " tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, " in_ack"}, 32'(in_ack), 32'd0);
        chk({tag, " in_data"}, in_data, 32'd0);
        chk({tag, " out_ack"}, 32'(out_ack), 32'd0);
        chk({tag, " rx_count"}, 32'(rx_count), 32'd0);
        chk({tag, " rx_overflow"}, 32'(rx_overflow), 32'd0);
        chk({tag, " stat_rx_total"}, stat_rx_total, 32'd0);
        chk({tag, " stat_rx_drop"}, stat_rx_drop, 32'd0);
    endtask

    task automatic model_reset();
        m_rx.delete(); m_ovf = 0; m_total = 0; m_drop = 0;
        exp_in_q.delete(); exp_tx_q.delete();
        tx_pushed = 0; tx_started = 0;
    endtask

    initial begin
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (rstn) begin
                        if (in_ack) begin
                            if (exp_in_q.size() == 0) chk("unexpected in_ack", 32'(in_ack), 32'd0);
                            else chk("in_data", in_data, exp_in_q.pop_front());
                        end
                        if (tx_start) begin
                            chk("tx_start while busy", 32'(tx_busy), 32'd0);
                            tx_started++;
                            if (exp_tx_q.size() == 0) chk("unexpected tx_start", 32'(tx_start), 32'd0);
                            else chk("tx_data", 32'(tx_data), 32'(exp_tx_q.pop_front()));
                        end
                    end
                end
            end
            begin : stimulus
                int a;
                bit seen;
                repeat (3) @(negedge clk);
                check_all_zero("reset");
                rstn = 1'b1;
                repeat (2) @(negedge clk);
                check_all_zero("post-reset");

                // Single byte and little-endian word.
                push_byte(8'h41, 0);
                check_rx_state("one byte");
                do_in(0);
                check_rx_state("byte read");
                push_byte(8'h78, 0); push_byte(8'h56, 0);
                push_byte(8'h34, 0); push_byte(8'h12, 0);
                do_in(1);
                check_rx_state("word read");

                // Word request waits for the fourth byte.
                push_byte(8'hA1, 0); push_byte(8'hA2, 0); push_byte(8'hA3, 0);
                tick();
                in_word = 1'b1; in_req = 1'b1;
                seen = 0;
                repeat (10) begin @(negedge clk); if (in_ack) seen = 1; end
                chk("3-byte word acked", 32'(seen), 32'd0);
                tick();
                rx_data = 8'hA4; rx_ready = 1'b1; a = cyc;
                model_push(8'hA4, 0);
                exp_in_q.push_back(model_pop(4));
                tick();
                rx_ready = 1'b0;
                seen = 0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (in_ack) begin seen = 1; break; end
                end
                in_req = 1'b0;
                chk("late word ack seen", 32'(seen), 32'd1);
                chk("late word ack cycle", cyc - a, 6);
                check_rx_state("late word");

                // Overflow, ferr while full, clear racing a new overflow.
                for (int i = 1; i <= 5; i++) push_byte(8'(i), 0);
                check_rx_state("overflow");
                push_byte(8'hEE, 1);
                check_rx_state("ferr while full");
                tick();
                rx_data = 8'h06; rx_ready = 1'b1; clr_overflow = 1'b1;
                m_ovf = 0; model_push(8'h06, 0);
                tick();
                rx_ready = 1'b0; clr_overflow = 1'b0;
                check_rx_state("clr vs overflow");
                pulse_clr();
                check_rx_state("clr");
                do_in(1);
                check_rx_state("overflow readback");

                // Push in the same cycle as an IN pop, not full then full.
                push_byte(8'h11, 0);
                exp_in_q.push_back(model_pop(1));
                tick();
                in_word = 1'b0; in_req = 1'b1;
                tick();
                rx_data = 8'h22; rx_ready = 1'b1;
                model_push(8'h22, 0);
                tick();
                rx_ready = 1'b0;
                @(negedge clk);
                chk("ack with push", 32'(in_ack), 32'd1);
                in_req = 1'b0;
                check_rx_state("push+pop");
                do_in(0);
                for (int i = 0; i < 4; i++) push_byte(8'h31 + 8'(i), 0);
                exp_in_q.push_back(model_pop(1));
                tick();
                in_word = 1'b0; in_req = 1'b1;
                tick();
                rx_data = 8'h35; rx_ready = 1'b1;
                m_ovf = 1; m_drop++;
                tick();
                rx_ready = 1'b0;
                @(negedge clk);
                chk("ack with full push", 32'(in_ack), 32'd1);
                in_req = 1'b0;
                check_rx_state("full push+pop");
                do_in(0); do_in(0); do_in(0);
                pulse_clr();
                check_rx_state("drained");

                // Word OUT with a busy transmitter.
                busy_len = 5;
                a = tx_started;
                do_out(1, 32'hDEADBEEF);
                wait_tx_drain();
                chk("DEADBEEF tx_start count", tx_started - a, 4);

                // Randomised traffic.
                for (int it = 0; it < 250; it++) begin
                    int op = $urandom_range(0, 9);
                    if (op <= 3) begin
                        push_byte(8'($urandom), $urandom_range(0, 7) == 0);
                        check_rx_state("rand push");
                    end else if (op <= 5) begin
                        bit w = 1'($urandom_range(0, 1));
                        if (m_rx.size() >= (w ? 4 : 1)) do_in(w);
                        else do_in_starved(w);
                        check_rx_state("rand in");
                    end else if (op == 6) begin
                        pulse_clr();
                        check_rx_state("rand clr");
                    end else if (op <= 8) begin
                        busy_len = $urandom_range(1, 8);
                        do_out(1'($urandom_range(0, 1)), $urandom);
                    end else begin
                        repeat ($urandom_range(1, 6)) tick();
                    end
                end
                wait_tx_drain();
                check_rx_state("rand end");

                // Reset during IN_FETCH.
                for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i), 0);
                tick();
                in_word = 1'b1; in_req = 1'b1;
                tick();
                rstn = 1'b0;
                #1;
                in_req = 1'b0;
                model_reset();
                check_all_zero("reset in fetch");
                repeat (2) @(negedge clk);
                rstn = 1'b1;
                repeat (10) @(negedge clk);
                check_rx_state("after fetch reset");

                // Reset during TX_START.
                busy_len = 3;
                do_out(1, $urandom);
                seen = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (tx_start) begin seen = 1; break; end
                end
                chk("tx_start before reset", 32'(seen), 32'd1);
                rstn = 1'b0;
                #1;
                chk("tx_start in reset", 32'(tx_start), 32'd0);
                chk("tx_data in reset", 32'(tx_data), 32'd0);
                model_reset();
                repeat (2) @(negedge clk);
                rstn = 1'b1;
                seen = 0;
                repeat (30) begin @(negedge clk); if (tx_start) seen = 1; end
                chk("tx_start after reset", 32'(seen), 32'd0);
                check_rx_state("after tx reset");

                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        join
    end

endmodule
